// File: rtl/bvudiv_inv_ne_solver_if.sv
// Handshake bundle for the bvudiv_inv_ne_solver: request operands in, search status and witness out.
interface bvudiv_inv_ne_solver_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] s;
  logic [W-1:0] t;
  logic         busy;
  logic         done;
  logic         found;
  logic [W-1:0] x;

  modport master (output start, s, t, input  busy, done, found, x);
  modport slave  (input  start, s, t, output busy, done, found, x);
endinterface

// File: rtl/bvudiv_inv_ne_solver.sv
// Finds the smallest x with (x udiv s) != t (POS=0) or (s udiv x) != t (POS=1)
// by ascending candidate search, one restoring-division bit per cycle.
module bvudiv_inv_ne_solver #(
  parameter int W   = 4,
  parameter int POS = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  bvudiv_inv_ne_solver_if.slave      bus
);
  typedef enum logic [2:0] {IDLE, LOAD, DIV, CHECK, FIN} state_t;

  localparam int           CW   = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] ONES = '1;

  state_t        state;
  logic [W-1:0]  c;
  logic [W-1:0]  s_r;
  logic [W-1:0]  t_r;
  logic [W-1:0]  d_r;
  logic [W-1:0]  quo;
  logic [W-1:0]  rem;
  logic [CW-1:0] cnt;
  logic          busy_r;
  logic          done_r;
  logic          found_r;
  logic [W-1:0]  x_r;

  logic [W-1:0]  ld_n;
  logic [W-1:0]  ld_d;
  logic [W:0]    trial;
  logic [W:0]    diff;
  logic          ge;

  // NOTE: every signal gets a value before any branch, so no latch can be inferred.
  always_comb begin
    ld_n  = (POS != 0) ? s_r : c;
    ld_d  = (POS != 0) ? c   : s_r;
    trial = {rem, quo[W-1]};
    diff  = trial - {1'b0, d_r};
    ge    = (trial >= {1'b0, d_r});
  end

  // The quotient register doubles as the dividend shift register; bits shift
  // out of the top into the remainder while result bits enter at the bottom.
  // NOTE: all state here uses non-blocking assignment so every register sees
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      c       <= '0;
      s_r     <= '0;
      t_r     <= '0;
      d_r     <= '0;
      quo     <= '0;
      rem     <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      found_r <= 1'b0;
      x_r     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            s_r     <= bus.s;
            t_r     <= bus.t;
            c       <= '0;
            busy_r  <= 1'b1;
            found_r <= 1'b0;
            x_r     <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (ld_d != '0) begin
            d_r   <= ld_d;
            quo   <= ld_n;
            rem   <= '0;
            cnt   <= CW'(W - 1);
            state <= DIV;
          end else begin
            // Division by zero yields all-ones without running the divider.
            quo   <= ONES;
            state <= CHECK;
          end
        end
        DIV: begin
          rem <= ge ? diff[W-1:0] : trial[W-1:0];
          quo <= (quo << 1) | W'(ge);
          if (cnt == '0) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CHECK: begin
          if (quo != t_r) begin
            x_r     <= c;
            found_r <= 1'b1;
            state   <= FIN;
          end else if (c == ONES) begin
            x_r     <= '0;
            found_r <= 1'b0;
            state   <= FIN;
          end else begin
            c     <= c + 1'b1;
            state <= LOAD;
          end
        end
        FIN: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.found = found_r;
  assign bus.x     = x_r;
endmodule
